// File: rtl/ps2_move_decoder.sv
// PS/2 keyboard front-end: conditions the raw pins, deframes set-2 scan codes and
// turns W/A/D and arrow presses into held MOVE/LEFT/RIGHT commands with ack handshake.
module ps2_move_decoder #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic       clk_in,
    input  logic       reset_btn,
    input  logic       ps2_clock,
    input  logic       ps2_data,
    output logic [1:0] cmd_data,
    output logic       cmd_valid,
    input  logic       cmd_ack,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       frame_err,
    output logic [7:0] drop_cnt
);

    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FCW-1:0] FILT_MAX = FCW'(FILTER_LEN - 1);
    localparam logic [TCW-1:0] TO_MAX   = TCW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, CHECK} frameState_t;
    typedef enum logic [1:0] {NORM, BRK, EXT, EXT_BRK} scanState_t;

    logic [1:0]     clkSync_q, datSync_q;
    logic           clkS, datS;
    logic           filtLevel_q, filtLevel_d;
    logic [FCW-1:0] filtCnt_q, filtCnt_d;
    logic           fe_q, fe_d;

    frameState_t    frameState_q, frameState_d;
    logic [9:0]     shift_q, shift_d;
    logic [3:0]     bitCnt_q, bitCnt_d;
    logic [TCW-1:0] toCnt_q, toCnt_d;
    logic           timeout, frameGood, byteLoad, errPulse;

    scanState_t     scanState_q, scanState_d;
    logic           isMake, isBreak, isExt;
    logic [1:0]     keyCode;
    logic [2:0]     keyMask;
    logic           issue;
    logic [2:0]     held_q, held_d;

    logic [1:0]     cmdData_q, cmdData_d;
    logic           cmdValid_q, cmdValid_d;
    logic [7:0]     dropCnt_q, dropCnt_d;
    logic [7:0]     byteData_q;
    logic           byteValid_q, frameErr_q;

    always_ff @(posedge clk_in or posedge reset_btn) begin
        if (reset_btn) begin
            clkSync_q <= 2'b11;
            datSync_q <= 2'b11;
        end else begin
            clkSync_q <= {clkSync_q[0], ps2_clock};
            datSync_q <= {datSync_q[0], ps2_data};
        end
    end

    assign clkS = clkSync_q[1];
    assign datS = datSync_q[1];

    // Glitch filter: the level only flips after FILTER_LEN consecutive differing samples.
    always_comb begin
        filtLevel_d = filtLevel_q;
        filtCnt_d   = '0;
        fe_d        = 1'b0;
        if (clkS != filtLevel_q) begin
            if (filtCnt_q == FILT_MAX) begin
                filtLevel_d = ~filtLevel_q;
                fe_d        = filtLevel_q;
            end else begin
                filtCnt_d = filtCnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or posedge reset_btn) begin
        if (reset_btn) begin
            filtLevel_q <= 1'b1;
            filtCnt_q   <= '0;
            fe_q        <= 1'b0;
        end else begin
            filtLevel_q <= filtLevel_d;
            filtCnt_q   <= filtCnt_d;
            fe_q        <= fe_d;
        end
    end

    assign timeout   = (frameState_q == SHIFT) && !fe_q && (toCnt_q == TO_MAX);
    assign frameGood = shift_q[9] && (^shift_q[8:0]);

    always_ff @(posedge clk_in or posedge reset_btn) begin
        if (reset_btn) frameState_q <= IDLE;
        else           frameState_q <= frameState_d;
    end

    always_comb begin
        frameState_d = frameState_q;
        case (frameState_q)
            IDLE:    if (fe_q && !datS) frameState_d = SHIFT;
            SHIFT: begin
                if (timeout)                         frameState_d = IDLE;
                else if (fe_q && bitCnt_q == 4'd10)  frameState_d = CHECK;
            end
            CHECK:   frameState_d = IDLE;
            default: frameState_d = IDLE;
        endcase
    end

    always_comb begin
        byteLoad = (frameState_q == CHECK) && frameGood;
        errPulse = ((frameState_q == CHECK) && !frameGood) || timeout;
    end

    // Shift register fills LSB first: [7:0] data, [8] parity, [9] stop.
    always_comb begin
        shift_d  = shift_q;
        bitCnt_d = bitCnt_q;
        toCnt_d  = (frameState_q != SHIFT || fe_q) ? '0 : toCnt_q + 1'b1;
        if (fe_q) begin
            if (frameState_q == IDLE && !datS) begin
                bitCnt_d = 4'd1;
            end else if (frameState_q == SHIFT) begin
                shift_d  = {datS, shift_q[9:1]};
                bitCnt_d = bitCnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk_in or posedge reset_btn) begin
        if (reset_btn) begin
            shift_q     <= '0;
            bitCnt_q    <= '0;
            toCnt_q     <= '0;
            byteData_q  <= 8'h00;
            byteValid_q <= 1'b0;
            frameErr_q  <= 1'b0;
        end else begin
            shift_q     <= shift_d;
            bitCnt_q    <= bitCnt_d;
            toCnt_q     <= toCnt_d;
            byteValid_q <= byteLoad;
            frameErr_q  <= errPulse;
            if (byteLoad) byteData_q <= shift_q[7:0];
        end
    end

    always_ff @(posedge clk_in or posedge reset_btn) begin
        if (reset_btn) scanState_q <= NORM;
        else           scanState_q <= scanState_d;
    end

    always_comb begin
        scanState_d = scanState_q;
        if (byteValid_q) begin
            case (scanState_q)
                NORM: begin
                    if (byteData_q == 8'hE0)      scanState_d = EXT;
                    else if (byteData_q == 8'hF0) scanState_d = BRK;
                    else                          scanState_d = NORM;
                end
                EXT:     scanState_d = (byteData_q == 8'hF0) ? EXT_BRK : NORM;
                default: scanState_d = NORM;
            endcase
        end
    end

    always_comb begin
        isMake  = byteValid_q &&
                  (((scanState_q == NORM) && byteData_q != 8'hE0 && byteData_q != 8'hF0) ||
                   ((scanState_q == EXT) && byteData_q != 8'hF0));
        isBreak = byteValid_q && (scanState_q == BRK || scanState_q == EXT_BRK);
        isExt   = (scanState_q == EXT || scanState_q == EXT_BRK);
    end

    always_comb begin
        keyCode = 2'b00;
        case ({isExt, byteData_q})
            {1'b0, 8'h1D}, {1'b1, 8'h75}: keyCode = 2'b01;
            {1'b0, 8'h1C}, {1'b1, 8'h6B}: keyCode = 2'b10;
            {1'b0, 8'h23}, {1'b1, 8'h74}: keyCode = 2'b11;
            default:                      keyCode = 2'b00;
        endcase
        case (keyCode)
            2'b01:   keyMask = 3'b001;
            2'b10:   keyMask = 3'b010;
            2'b11:   keyMask = 3'b100;
            default: keyMask = 3'b000;
        endcase
    end

    // A held key only issues once; a new issue beats a coincident ack.
    always_comb begin
        issue      = isMake && (keyCode != 2'b00) && ((held_q & keyMask) == 3'b000);
        held_d     = held_q;
        cmdData_d  = cmdData_q;
        cmdValid_d = cmdValid_q;
        dropCnt_d  = dropCnt_q;
        if (isMake)  held_d = held_q | keyMask;
        if (isBreak) held_d = held_q & ~keyMask;
        if (issue) begin
            if (!cmdValid_q || cmd_ack) begin
                cmdData_d  = keyCode;
                cmdValid_d = 1'b1;
            end else if (dropCnt_q != 8'hFF) begin
                dropCnt_d = dropCnt_q + 8'd1;
            end
        end else if (cmd_ack) begin
            cmdValid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in or posedge reset_btn) begin
        if (reset_btn) begin
            held_q     <= 3'b000;
            cmdData_q  <= 2'b00;
            cmdValid_q <= 1'b0;
            dropCnt_q  <= 8'h00;
        end else begin
            held_q     <= held_d;
            cmdData_q  <= cmdData_d;
            cmdValid_q <= cmdValid_d;
            dropCnt_q  <= dropCnt_d;
        end
    end

    assign cmd_data   = cmdData_q;
    assign cmd_valid  = cmdValid_q;
    assign byte_data  = byteData_q;
    assign byte_valid = byteValid_q;
    assign frame_err  = frameErr_q;
    assign drop_cnt   = dropCnt_q;

endmodule

// File: tb/tb_ps2_move_decoder.sv
// Directed bench for ps2_move_decoder: bit-bangs PS/2 frames and checks bytes,
// errors, commands, repeat suppression and the drop/ack handshake.
module tb_ps2_move_decoder;

    localparam int FILT = 8;
    localparam int TMO  = 10000;
    localparam int HALF = 30;

    logic       clk_in    = 1'b0;
    logic       reset_btn = 1'b1;
    logic       ps2_clock = 1'b1;
    logic       ps2_data  = 1'b1;
    logic       cmd_ack   = 1'b0;
    logic [1:0] cmd_data;
    logic       cmd_valid;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       frame_err;
    logic [7:0] drop_cnt;

    int checkCount = 0, passCount = 0;
    int cycleCnt = 0, bvCount = 0, errCount = 0, lastErrCycle = 0, lastFallCycle = 0;
    int bv0, err0, delta;
    logic seen;

    ps2_move_decoder #(.FILTER_LEN(FILT), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_in(clk_in), .reset_btn(reset_btn), .ps2_clock(ps2_clock), .ps2_data(ps2_data),
        .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ack(cmd_ack),
        .byte_data(byte_data), .byte_valid(byte_valid), .frame_err(frame_err),
        .drop_cnt(drop_cnt)
    );

    always #5 clk_in = ~clk_in;

    always @(negedge clk_in) begin
        cycleCnt++;
        if (byte_valid) bvCount++;
        if (frame_err) begin
            errCount++;
            lastErrCycle = cycleCnt;
        end
    end

    task checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got === exp) passCount++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task tick(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #2;
        end
    endtask

    // Drives the first n bits of an 11-bit frame, bit 0 first; data changes while the clock is high.
    task applyStimulus(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            tick(HALF);
            ps2_clock     = 1'b0;
            lastFallCycle = cycleCnt;
            tick(HALF);
            ps2_clock = 1'b1;
        end
        tick(HALF);
        ps2_data = 1'b1;
    endtask

    function automatic logic [10:0] frameOf(input logic [7:0] b, input logic badPar);
        return {1'b1, (~^b) ^ badPar, b, 1'b0};
    endfunction

    task sendByte(input logic [7:0] b);
        applyStimulus(frameOf(b, 1'b0), 11);
    endtask

    task ackPulse;
        cmd_ack = 1'b1;
        tick(1);
        cmd_ack = 1'b0;
    endtask

    initial begin
        tick(5);
        reset_btn = 1'b0;
        tick(20);
        checkOutput("rstCmdValid", cmd_valid, 0);
        checkOutput("rstCmdData", cmd_data, 0);
        checkOutput("rstByteData", byte_data, 0);
        checkOutput("rstByteValid", byte_valid, 0);
        checkOutput("rstFrameErr", frame_err, 0);
        checkOutput("rstDropCnt", drop_cnt, 0);
        checkOutput("rstNoPulses", bvCount + errCount, 0);

        // Reset mid-frame, then a clean W
        applyStimulus(frameOf(8'h1D, 1'b0), 5);
        reset_btn = 1'b1;
        tick(3);
        reset_btn = 1'b0;
        tick(5);
        bv0 = bvCount; err0 = errCount;
        sendByte(8'h1D);
        checkOutput("midRstByteCount", bvCount - bv0, 1);
        checkOutput("midRstByteData", byte_data, 8'h1D);
        checkOutput("midRstErrCount", errCount - err0, 0);
        checkOutput("wValid", cmd_valid, 1);
        checkOutput("wData", cmd_data, 2'b01);
        tick(100);
        checkOutput("wHeldValid", cmd_valid, 1);
        checkOutput("wHeldData", cmd_data, 2'b01);
        ackPulse();
        checkOutput("wAckClears", cmd_valid, 0);
        sendByte(8'hF0); sendByte(8'h1D);
        checkOutput("wBreakNoCmd", cmd_valid, 0);

        // Extended Left with auto-repeat
        for (int k = 0; k < 3; k++) begin
            sendByte(8'hE0); sendByte(8'h6B);
            checkOutput("extRepeatValid", cmd_valid, (k == 0) ? 1 : 0);
            if (k == 0) checkOutput("extLeftData", cmd_data, 2'b10);
            if (cmd_valid) ackPulse();
        end
        sendByte(8'hE0); sendByte(8'hF0); sendByte(8'h6B);
        checkOutput("extBreakNoCmd", cmd_valid, 0);
        sendByte(8'hE0); sendByte(8'h6B);
        checkOutput("extSecondValid", cmd_valid, 1);
        checkOutput("extSecondData", cmd_data, 2'b10);
        ackPulse();
        sendByte(8'hE0); sendByte(8'hF0); sendByte(8'h6B);
        checkOutput("dropCntStill0", drop_cnt, 0);

        // Parity error then good D
        bv0 = bvCount; err0 = errCount;
        applyStimulus(frameOf(8'h23, 1'b1), 11);
        checkOutput("parErrCount", errCount - err0, 1);
        checkOutput("parNoByte", bvCount - bv0, 0);
        checkOutput("parNoCmd", cmd_valid, 0);
        sendByte(8'h23);
        checkOutput("rightValid", cmd_valid, 1);
        checkOutput("rightData", cmd_data, 2'b11);
        ackPulse();
        sendByte(8'hF0); sendByte(8'h23);

        // Timeout on a partial frame
        bv0 = bvCount; err0 = errCount;
        applyStimulus(frameOf(8'h1C, 1'b0), 4);
        tick(12000);
        delta = lastErrCycle - lastFallCycle;
        checkOutput("toErrCount", errCount - err0, 1);
        checkOutput("toNoByte", bvCount - bv0, 0);
        checkOutput("toDelayWindow", (delta >= TMO + 10 && delta <= TMO + 14) ? 1 : 0, 1);
        sendByte(8'h1C);
        checkOutput("toAfterValid", cmd_valid, 1);
        checkOutput("toAfterData", cmd_data, 2'b10);
        ackPulse();
        sendByte(8'hF0); sendByte(8'h1C);

        // Drop while pending, then issue coinciding with ack
        sendByte(8'h1D);
        sendByte(8'hF0); sendByte(8'h1D);
        sendByte(8'h23);
        checkOutput("dropValid", cmd_valid, 1);
        checkOutput("dropKeepsData", cmd_data, 2'b01);
        checkOutput("dropCount", drop_cnt, 1);
        seen = 1'b0;
        fork
            sendByte(8'h1C);
            begin
                for (int i = 0; i < 2000 && !seen; i++) begin
                    @(negedge clk_in);
                    if (byte_valid) begin
                        seen    = 1'b1;
                        cmd_ack = 1'b1;
                        @(posedge clk_in);
                        #2;
                        cmd_ack = 1'b0;
                    end
                end
            end
        join
        checkOutput("coinByteSeen", seen, 1);
        checkOutput("coinValid", cmd_valid, 1);
        checkOutput("coinData", cmd_data, 2'b10);
        checkOutput("coinNoDrop", drop_cnt, 1);
        ackPulse();
        sendByte(8'h23);
        checkOutput("droppedHeldByte", byte_data, 8'h23);
        checkOutput("droppedStillHeld", cmd_valid, 0);
        checkOutput("droppedNoNewDrop", drop_cnt, 1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
